// File: rtl/div_iter_unit_pkg.sv
// Shared types and constants for the iterative divider and the EXE decode that feeds it.
package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    localparam int DIV_ITER = 32;

    // MDU ALUOp codes that EXE decodes into div_start / div_signed
    localparam logic [3:0] ALUOP_DIV  = 4'b1010;
    localparam logic [3:0] ALUOP_DIVU = 4'b1011;

endpackage

// File: rtl/div_iter_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module div_iter_step (
    input  logic [32:0] rem_in,
    input  logic [31:0] divisor,
    input  logic        bit_in,
    output logic [32:0] rem_out,
    output logic        q_bit
);

    logic [33:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted[32:0] - {1'b0, divisor};
        q_bit   = (shifted >= {2'b00, divisor});
        rem_out = q_bit ? diff : shifted[32:0];
    end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU) for EXE; stalls EXE while busy.
//
// state    | meaning
// DIV_IDLE | waiting for div_start; operands latched on acceptance
// DIV_BUSY | one restoring step per cycle, 32 steps MSB first
// DIV_DONE | results valid, div_finish high until pipe_adv or flush
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    input  logic             flush,
    input  logic             pipe_adv,
    output logic             div_stall,
    output logic             div_finish,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder
);

    div_state_t  state;
    logic [4:0]  cnt;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;

    logic [32:0] rem_nxt;
    logic        q_bit;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        a_neg  = div_signed & dividend[31];
        b_neg  = div_signed & divisor[31];
        b_zero = (divisor == 32'd0);
        a_mag  = a_neg ? (32'd0 - dividend) : dividend;
        b_mag  = b_neg ? (32'd0 - divisor) : divisor;
    end

    // quo_q starts as the dividend and is shifted out MSB first as quotient bits shift in
    div_iter_step u_step (
        .rem_in  (rem_q),
        .divisor (dsr_q),
        .bit_in  (quo_q[31]),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= DIV_IDLE;
            cnt      <= 5'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            dsr_q    <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else if (flush) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_start) begin
                        state    <= DIV_BUSY;
                        cnt      <= 5'd0;
                        rem_q    <= 33'd0;
                        // divide-by-zero keeps the raw dividend so the remainder is uncorrected
                        quo_q    <= b_zero ? dividend : a_mag;
                        dsr_q    <= b_mag;
                        q_neg    <= (a_neg ^ b_neg) & ~b_zero;
                        r_neg    <= a_neg & ~b_zero;
                        div_zero <= b_zero;
                    end
                end
                DIV_BUSY: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[30:0], q_bit};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'(DIV_ITER - 1)) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (pipe_adv) begin
                        state <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        div_stall  = ~flush & (((state == DIV_IDLE) & div_start) | (state == DIV_BUSY));
        div_finish = (state == DIV_DONE);
        if (div_zero) begin
            quotient = 32'hFFFF_FFFF;
        end else begin
            quotient = q_neg ? (32'd0 - quo_q) : quo_q;
        end
        remainder = r_neg ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed corner cases plus random DIV/DIVU traffic.
module tb_div_iter_unit;
    import div_iter_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        flush = 1'b0;
    logic        pipe_adv = 1'b0;
    logic        div_stall;
    logic        div_finish;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_tests = 0;
    int n_fail  = 0;

    div_iter_unit #(.DIV_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_start  (div_start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .pipe_adv   (pipe_adv),
        .div_stall  (div_stall),
        .div_finish (div_finish),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result: truncating division, remainder takes the dividend's sign.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int          cyc;
        int          stalls;
        bit          done;
        ref_div(sgn, a, b, eq, er);
        tick();
        div_start  = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        pipe_adv   = 1'b0;
        flush      = 1'b0;
        cyc        = 0;
        stalls     = 0;
        done       = 1'b0;
        while (!done && cyc < 100) begin
            #1;
            if (div_finish) begin
                done = 1'b1;
            end else begin
                if (div_stall) stalls++;
                tick();
                cyc++;
            end
        end
        chk({tag, " finished"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'd33);
        chk({tag, " stall_cycles"}, 32'(stalls), 32'd33);
        chk({tag, " stall_in_done"}, 32'(div_stall), 32'd0);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        for (int i = 0; i < hold; i++) begin
            tick();
            #1;
            chk({tag, " hold_finish"}, 32'(div_finish), 32'd1);
            chk({tag, " hold_stall"}, 32'(div_stall), 32'd0);
            chk({tag, " hold_quotient"}, quotient, eq);
            chk({tag, " hold_remainder"}, remainder, er);
        end
        pipe_adv  = 1'b1;
        div_start = 1'b0;
        tick();
        pipe_adv = 1'b0;
        #1;
        chk({tag, " idle_finish"}, 32'(div_finish), 32'd0);
        chk({tag, " idle_stall"}, 32'(div_stall), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          fin_seen;

        #1;
        chk("reset stall", 32'(div_stall), 32'd0);
        chk("reset finish", 32'(div_finish), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        tick();
        resetn = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_div(1'b0, 32'd5, 32'd0, 0, "divu_5_0");
        run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 0, "div_neg_0");
        run_div(1'b1, 32'h8000_0000, 32'd1, 0, "div_min_1");

        // flush in cycle 10 of a divide
        tick();
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        #1;
        chk("flush stall", 32'(div_stall), 32'd0);
        chk("flush finish", 32'(div_finish), 32'd0);
        tick();
        flush     = 1'b0;
        div_start = 1'b0;
        #1;
        chk("post_flush stall", 32'(div_stall), 32'd0);
        chk("post_flush finish", 32'(div_finish), 32'd0);
        fin_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            #1;
            if (div_finish || div_stall) fin_seen = 1'b1;
        end
        chk("flush no_finish", 32'(fin_seen), 32'd0);
        run_div(1'b0, 32'd9, 32'd3, 0, "divu_9_3");

        // DONE held with div_start still high, no restart
        run_div(1'b1, 32'hFFFF_FC18, 32'd37, 5, "hold");

        // reset pulse in cycle 15
        tick();
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'h1234_5678;
        divisor    = 32'd7;
        for (int i = 0; i < 15; i++) tick();
        div_start = 1'b0;
        resetn    = 1'b0;
        #1;
        chk("rst stall", 32'(div_stall), 32'd0);
        chk("rst finish", 32'(div_finish), 32'd0);
        chk("rst quotient", quotient, 32'd0);
        chk("rst remainder", remainder, 32'd0);
        tick();
        resetn = 1'b1;
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 0, "divu_after_rst");

        for (int n = 0; n < 24; n++) begin
            op = ($urandom_range(0, 1) == 1) ? ALUOP_DIV : ALUOP_DIVU;
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = 32'd0 - 32'($urandom_range(1, 15));
                2:       b = (n % 6 == 0) ? 32'd0 : 32'd1;
                3:       b = $urandom >> $urandom_range(0, 28);
                default: b = $urandom;
            endcase
            run_div(op == ALUOP_DIV, a, b, 0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
